// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant, grant frozen mid-burst, MaxHold pre-emption.
// Define AHB_ARB_LOCK_EN to honour per-manager lock requests (HMASTLOCK); otherwise lock is ignored.
module ahb_arbiter #(
  parameter int NumManagers = 4,
  parameter int MaxHold     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NumManagers-1:0]         req,
  input  logic [NumManagers-1:0]         lock,
  input  logic [2*NumManagers-1:0]       trans,
  input  logic                           ready,
  output logic [NumManagers-1:0]         grant,
  output logic [$clog2(NumManagers)-1:0] owner,
  output logic [$clog2(NumManagers)-1:0] dataOwner,
  output logic                           mastLock
);
  localparam int IdxW  = $clog2(NumManagers);
  localparam int HoldW = $clog2(MaxHold + 1);
  localparam logic [1:0] TransIdle   = 2'd0;
  localparam logic [1:0] TransNonseq = 2'd2;

  typedef enum logic {OWN, BURST} state_e;

  state_e                 state_q, state_d;
  logic [NumManagers-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [IdxW-1:0]        data_owner_q, data_owner_d;
  logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   mast_lock_q, mast_lock_d;

  logic [1:0]             owner_trans;
  logic [NumManagers-1:0] others;
  logic [IdxW-1:0]        winner;
  logic                   found;
  logic                   hold_reached;
  logic                   burst_end;
  logic                   change_ok;
  logic                   rearb;
  logic                   do_switch;

  always_comb begin
    owner_trans = TransIdle;
    for (int i = 0; i < NumManagers; i++) begin
      if (owner_q == IdxW'(i)) owner_trans = trans[2*i +: 2];
    end

    others       = req & ~grant_q;
    hold_reached = (hold_cnt_q >= HoldW'(MaxHold));
    burst_end    = (state_q == BURST) &&
                   ((owner_trans == TransIdle) || (owner_trans == TransNonseq));
    change_ok    = ready && ((state_q == OWN) || burst_end) && !mast_lock_q;
    rearb        = !req[owner_q] || (hold_reached && (|others));

    // Round-robin: first requester above the owner, then wrap to the lowest index.
    winner = owner_q;
    found  = 1'b0;
    for (int i = 0; i < NumManagers; i++) begin
      if (!found && others[i] && (IdxW'(i) > owner_q)) begin
        winner = IdxW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NumManagers; i++) begin
      if (!found && others[i] && (IdxW'(i) < owner_q)) begin
        winner = IdxW'(i);
        found  = 1'b1;
      end
    end
    if (!found && !req[owner_q]) winner = '0;

    do_switch = change_ok && rearb && (winner != owner_q);
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    data_owner_d = data_owner_q;
    hold_cnt_d   = hold_cnt_q;
    mast_lock_d  = 1'b0;

    if (ready) begin
      data_owner_d = owner_q;
      if ((state_q == OWN) && (owner_trans == TransNonseq)) begin
        state_d = BURST;
      end else if (burst_end) begin
        state_d = OWN;
      end
    end

`ifdef AHB_ARB_LOCK_EN
    mast_lock_d = mast_lock_q;
    if (ready) mast_lock_d = lock[owner_q];
`endif

    if (do_switch) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      owner_d         = winner;
      hold_cnt_d      = '0;
    end else if (ready && (|others) && !hold_reached) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

`ifndef AHB_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OWN;
      grant_q      <= {{(NumManagers-1){1'b0}}, 1'b1};
      owner_q      <= '0;
      data_owner_q <= '0;
      hold_cnt_q   <= '0;
      mast_lock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      mast_lock_q  <= mast_lock_d;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign dataOwner = data_owner_q;
  assign mastLock  = mast_lock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: vector table, directed corner sequences, random traffic vs. a reference model.
module tb_ahb_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 4;
`ifdef AHB_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif
  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [2*N-1:0] trans = '0;
  logic         ready = 1'b1;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic [1:0]   dataOwner;
  logic         mastLock;

  ahb_arbiter #(.NumManagers(N), .MaxHold(MAXH)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .trans(trans), .ready(ready),
    .grant(grant), .owner(owner), .dataOwner(dataOwner), .mastLock(mastLock)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_owner  = 0;
  bit m_burst  = 1'b0;
  int m_hold   = 0;
  int m_downer = 0;
  bit m_lock   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rs, input logic [3:0] rq, input logic [3:0] lk,
                            input logic [7:0] tr, input bit rdy);
    int  tr_own;
    int  nxt;
    int  cand;
    bit  others;
    bit  may_change;
    bit  want;
    bit  done;
    if (rs) begin
      m_owner = 0; m_burst = 0; m_hold = 0; m_downer = 0; m_lock = 0;
      return;
    end
    if (!rdy) return;
    tr_own     = int'((tr >> (2 * m_owner)) & 8'h3);
    others     = (rq & ~(4'b0001 << m_owner)) != 4'b0000;
    may_change = (!m_burst || tr_own == 0 || tr_own == 2) && !m_lock;
    want       = !rq[m_owner] || (m_hold >= MAXH && others);
    nxt        = m_owner;
    if (want) begin
      nxt  = rq[m_owner] ? m_owner : 0;
      done = 1'b0;
      for (int k = 1; k < N; k++) begin
        cand = (m_owner + k) % N;
        if (!done && rq[cand]) begin
          nxt  = cand;
          done = 1'b1;
        end
      end
    end
    m_downer = m_owner;
    m_lock   = LockEn ? lk[m_owner] : 1'b0;
    if (!m_burst && tr_own == 2) m_burst = 1'b1;
    else if (m_burst && (tr_own == 0 || tr_own == 2)) m_burst = 1'b0;
    if (may_change && nxt != m_owner) begin
      m_owner = nxt;
      m_hold  = 0;
    end else if (others && m_hold < MAXH) begin
      m_hold++;
    end
  endtask

  task automatic step(input bit rs, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [7:0] tr, input bit rdy);
    reset = rs; req = rq; lock = lk; trans = tr; ready = rdy;
    model_step(rs, rq, lk, tr, rdy);
    @(posedge clk);
    #1;
    check("model_grant", 32'(grant), 32'(1) << m_owner);
    check("model_owner", 32'(owner), 32'(m_owner));
    check("model_dataOwner", 32'(dataOwner), 32'(m_downer));
    check("model_mastLock", 32'(mastLock), 32'(m_lock));
  endtask

  function automatic logic [7:0] tr_of(input int m, input logic [1:0] t);
    return 8'(t) << (2 * m);
  endfunction

  typedef struct {
    bit         rs;
    logic [3:0] rq;
    logic [3:0] lk;
    logic [7:0] tr;
    bit         rdy;
    logic [3:0] eg;
    int         eo;
    int         edo;
    bit         eml;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 0, 0, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 0, 0, 1'b0};
    tbl[3] = '{1'b0, 4'b1010, 4'b0000, 8'h00, 1'b1, 4'b0010, 1, 0, 1'b0};
    tbl[4] = '{1'b0, 4'b1010, 4'b0000, 8'h00, 1'b1, 4'b0010, 1, 1, 1'b0};
    tbl[5] = '{1'b0, 4'b1000, 4'b0000, 8'h00, 1'b1, 4'b1000, 3, 1, 1'b0};
    tbl[6] = '{1'b0, 4'b1000, 4'b0000, 8'h00, 1'b0, 4'b1000, 3, 1, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'b1000, 3, 1, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 0, 3, 1'b0};

    // Reset, basic round-robin and ready=0 hold
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rs, tbl[i].rq, tbl[i].lk, tbl[i].tr, tbl[i].rdy);
      check("tbl_grant", 32'(grant), 32'(tbl[i].eg));
      check("tbl_owner", 32'(owner), 32'(tbl[i].eo));
      check("tbl_dataOwner", 32'(dataOwner), 32'(tbl[i].edo));
      check("tbl_mastLock", 32'(mastLock), 32'(tbl[i].eml));
    end

    // Burst NONSEQ + 3 SEQ with two wait states: grant frozen until burst ends
    step(0, 4'b0110, 4'b0000, 8'h00, 1);
    check("burst_setup", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, NONSEQ), 1);
    check("burst_nonseq", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, SEQ), 1);
    check("burst_seq1", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, SEQ), 0);
    check("burst_wait1", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, SEQ), 0);
    check("burst_wait2", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, SEQ), 1);
    check("burst_seq2", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, SEQ), 1);
    check("burst_seq3", 32'(grant), 32'(4'b0010));
    step(0, 4'b0110, 4'b0000, tr_of(1, IDLE), 1);
    check("burst_release", 32'(grant), 32'(4'b0100));

    // MaxHold pre-emption of a continuous NONSEQ stream
    for (int i = 0; i < MAXH; i++) begin
      step(0, 4'b0101, 4'b0000, tr_of(2, NONSEQ), 1);
      check("maxhold_keep", 32'(grant), 32'(4'b0100));
    end
    step(0, 4'b0101, 4'b0000, tr_of(2, NONSEQ), 1);
    check("maxhold_preempt", 32'(grant), 32'(4'b0001));

    // Locked sequence from manager 3
    step(0, 4'b1000, 4'b0000, 8'h00, 1);
    check("lock_setup", 32'(grant), 32'(4'b1000));
    for (int i = 0; i < 20; i++) begin
      step(0, 4'b1111, 4'b1000, 8'h00, 1);
      if (LockEn) begin
        check("lock_hold_grant", 32'(grant), 32'(4'b1000));
        check("lock_hold_mastLock", 32'(mastLock), 32'(1));
      end
    end
    step(0, 4'b1111, 4'b0000, 8'h00, 1);
    if (LockEn) check("lock_drop_still", 32'(grant), 32'(4'b1000));
    step(0, 4'b1111, 4'b0000, 8'h00, 1);
    if (LockEn) check("lock_drop_move", 32'(grant), 32'(4'b0001));

    // Reset in the middle of a burst owned by manager 2
    step(0, 4'b0100, 4'b0000, 8'h00, 1);
    check("rst_setup", 32'(grant), 32'(4'b0100));
    step(0, 4'b0100, 4'b0000, tr_of(2, NONSEQ), 1);
    step(0, 4'b0100, 4'b0000, tr_of(2, SEQ), 1);
    step(1, 4'b0100, 4'b0000, tr_of(2, SEQ), 1);
    check("rst_grant", 32'(grant), 32'(4'b0001));
    check("rst_owner", 32'(owner), 32'(0));
    check("rst_dataOwner", 32'(dataOwner), 32'(0));
    check("rst_mastLock", 32'(mastLock), 32'(0));
    // Manager 0 drives SEQ: only a state of OWN lets the grant move here
    step(0, 4'b0010, 4'b0000, tr_of(0, SEQ), 1);
    check("rst_state_own", 32'(grant), 32'(4'b0010));

    // Random traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      logic [3:0] rq;
      logic [3:0] lk;
      logic [7:0] tr;
      bit         rs;
      bit         rdy;
      rs  = ($urandom_range(0, 99) == 0);
      rq  = 4'($urandom);
      lk  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      tr  = 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      step(rs, rq, lk, tr, rdy);
      check("onehot", 32'($countones(grant)), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
